// File: rtl/ram_playback_ctrl.sv
// ram_playback_ctrl: records a generated pattern into an internal RAM and plays it back on a tick
module ram_playback_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int STEP     = 1,
    parameter int TICK_CNT = 50_000_000,
    parameter int LOOP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_flag,
    input  logic              rd_flag,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic [1:0]        state,
    output logic              loaded
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW = $clog2(TICK_CNT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [TW-1:0] TMAX = TW'(TICK_CNT - 1);
    localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);

    typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, READ = 2'b10, PAUSE = 2'b11} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_a;
    logic [DATA_W-1:0] data_q, data_d, pat_q, pat_d, ram_q;
    logic [TW-1:0]     tick_q, tick_d;
    logic              dv_q, dv_d, loaded_q, loaded_d, pend_q, pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // the single RAM port follows the write address while recording, otherwise the next display address
    assign ram_a = (state_q == WRITE) ? addr_q : addr_d;

    // next-state logic; pend_d marks a freshly selected address whose word lands in data next cycle
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tick_d   = tick_q;
        pat_d    = pat_q;
        loaded_d = loaded_q;
        pend_d   = 1'b0;
        data_d   = pend_q ? ram_q : data_q;
        dv_d     = pend_q;
        if (wr_flag && state_q != WRITE) begin
            state_d = WRITE;
            addr_d  = '0;
            pat_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (rd_flag && loaded_q) begin
                    state_d = READ;
                    addr_d  = '0;
                    tick_d  = '0;
                    pend_d  = 1'b1;
                end
                WRITE: begin
                    pat_d  = pat_q + STEP_W;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST) begin
                        state_d  = IDLE;
                        addr_d   = '0;
                        loaded_d = 1'b1;
                    end
                end
                READ: if (rd_flag) begin
                    state_d = PAUSE;
                end else if (tick_q == TMAX) begin
                    tick_d = '0;
                    if (addr_q == LAST && LOOP == 0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        pend_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                PAUSE: if (rd_flag) state_d = READ;
            endcase
        end
    end

    // control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            loaded_q <= 1'b0;
            tick_q   <= '0;
            pat_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            loaded_q <= loaded_d;
            tick_q   <= tick_d;
            pat_q    <= pat_d;
            pend_q   <= pend_d;
        end
    end

    // RAM array with registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == WRITE) mem_q[ram_a] <= pat_q;
        ram_q <= mem_q[ram_a];
    end

    assign addr       = addr_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign state      = state_q;
    assign loaded     = loaded_q;
endmodule

// File: doc/ram_playback_ctrl.md
Name: ram_playback_ctrl

Overview:
- Parametrised record/playback controller between the two key-filter flags (write key, read key) and the display path (data-flow/digit formatter → 74HC595 driver).
- Owns an internal single-port RAM (inferred array, DEPTH = 2**ADDR_W). A write-key pulse fills the RAM with a generated pattern.
- A read-key pulse plays the RAM back one word per TICK_CNT cycles, with pause/resume, optional looping and priority rules for simultaneous keys.

Parameters:
- ADDR_W, 8: RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8: RAM data width.
- STEP, 1: pattern increment. The word written at address a is (a*STEP) mod 2**DATA_W.
- TICK_CNT, 50_000_000: cycles between playback steps. The default is 1 s at 50 MHz. Must be ≥ 2.
- LOOP, 1: 1 = playback wraps from DEPTH-1 to 0; 0 = playback stops after DEPTH-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_flag  in  1  single-cycle pulse from the write-key filter.
- rd_flag  in  1  single-cycle pulse from the read-key filter.
- addr  out  ADDR_W  current RAM address: the write address in WRITE, the displayed address in READ/PAUSE.
- data  out  DATA_W  last word read from RAM; drives the display formatter.
- data_valid  out  1  one-cycle pulse when data updates.
- state  out  2  00 IDLE, 01 WRITE, 10 READ, 11 PAUSE.
- loaded  out  1  high once a complete write pass has finished.

Behaviour:
- Clock, reset and output registers:
  - One clock. Reset is asynchronous and active-low; rst_n=0 forces all registers immediately, independent of clk.
  - Reset values: addr=0, data=0, data_valid=0, state=IDLE, loaded=0, tick counter=0.
  - RAM contents are not reset.
  - All outputs are registered.
- IDLE:
  - wr_flag → WRITE, addr=0.
  - rd_flag with loaded=1 → READ, addr=0.
  - rd_flag with loaded=0 → ignored.
- WRITE:
  - One word per cycle: RAM[addr] ← (addr*STEP) mod 2**DATA_W, then addr+1.
  - After writing DEPTH-1: next cycle state=IDLE, addr=0, loaded=1. A pass lasts exactly DEPTH cycles.
  - wr_flag and rd_flag during WRITE are ignored.
  - The multiply is truncated to DATA_W. Use an accumulator (pattern += STEP each cycle), not a multiplier.
- READ:
  - On entry, the tick counter clears and RAM[addr] is read. The registered RAM output gives 1-cycle read latency.
  - data is loaded and data_valid pulses on the cycle after each new addr. The first pulse comes 2 cycles after rd_flag.
  - The tick counter counts to TICK_CNT-1, then addr advances and the counter clears. Each address is held exactly TICK_CNT cycles.
  - At addr=DEPTH-1 on tick: LOOP=1 → addr=0, continue. LOOP=0 → state=IDLE, addr and data hold their last values.
- PAUSE:
  - rd_flag in READ → PAUSE. The tick counter freezes, and addr and data hold.
  - rd_flag in PAUSE → READ. The counter resumes from its frozen value, with no extra data_valid pulse.
- Priority and boundaries:
  - wr_flag in READ or PAUSE aborts playback → WRITE with addr=0 (a re-record). loaded stays 1 through the new pass.
  - wr_flag and rd_flag in the same cycle: wr_flag wins in every state where it is accepted.
  - The tick counter is sized to clog2(TICK_CNT) bits. It must never wrap between ticks.
  - Reset asserted mid-WRITE or mid-READ returns to IDLE with loaded=0. A read key is then ignored until the next complete write.

Test Plan:
1. Reset, then rd_flag with no prior write (ADDR_W=3, TICK_CNT=4) → state stays 00, no data_valid.
2. wr_flag (ADDR_W=3, DATA_W=8, STEP=3) → state=01 for exactly 8 cycles, addr 0..7; then state=00, loaded=1. Backdoor RAM = 0,3,6,9,12,15,18,21.
3. After scenario 2, rd_flag with TICK_CNT=4, LOOP=1 → data_valid pulses every 4 cycles, first 2 cycles after rd_flag. data sequence 0,3,…,21, then wraps to 0.
4. Same with LOOP=0 → after addr 7 is held 4 cycles, state=00, data stays 21.
5. During READ at addr=2, rd_flag → state=11, addr/data frozen for 20 cycles. A second rd_flag → READ; addr=3 arrives after the remaining tick cycles.
6. wr_flag and rd_flag in the same cycle during READ → state=01, addr=0. Separately, rst_n low mid-WRITE → all outputs at reset values immediately, loaded=0.
